// File: rtl/flash_line_arbiter_pkg.sv
// Shared definitions for the flash line arbiter.
// Contents: FSM state encoding, address/line geometry constants and the
// line-address helper used by the arbiter datapath.
// Optional feature macro: FLASH_LINE_ARB_PREFETCH_EN (PF_* states are only
// reachable when it is defined).
package flash_line_arb_pkg;

  localparam int ADDR_W        = 24;
  localparam int DEF_LINE_SIZE = 128;
  localparam int LINE_BYTES    = DEF_LINE_SIZE / 8;
  localparam int LINE_OFS      = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PF_ISSUE,
    PF_WAIT
  } state_t;

  // Align a byte address down to its 16-byte line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:LINE_OFS], {LINE_OFS{1'b0}}};
  endfunction

endpackage

// File: rtl/flash_line_arbiter_if.sv
// Requester-side bus of the flash line arbiter.
// Signals: req (level request per requester), req_addr (flat 24-bit byte
// addresses, requester i at [24*i+23:24*i]), gnt / done (one-hot pulses),
// line (returned line data), busy (arbiter not idle).
// Modports: master = requester side, slave = arbiter side.
interface flash_line_arbiter_if
  import flash_line_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int LINE_SIZE = DEF_LINE_SIZE
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [LINE_SIZE-1:0]      line;
  logic                      busy;

  modport master (output req, req_addr, input gnt, done, line, busy);
  modport slave  (input req, req_addr, output gnt, done, line, busy);
endinterface

// File: rtl/flash_line_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports: req (request vector), rr_ptr (last winner), winner (first set bit
// found scanning upward from rr_ptr+1 with wrap), valid (any request set).
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               valid
);
  int               idx_i;
  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned infers a latch.
    winner = '0;
    valid  = 1'b0;
    idx_i  = 0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_i = (int'(rr_ptr) + k) % NUM_REQ;
      idx   = PTR_W'(idx_i);
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end
endmodule

// File: rtl/flash_line_arbiter.sv
// Round-robin arbiter sharing one flash line reader among NUM_REQ refill
// requesters. Sequences reader commands and routes the returned line back.
// Ports: clk, rst (synchronous, active high), bus (requester interface,
// slave modport), fr_addr / fr_rd (reader command), fr_done / fr_line
// (reader completion).
// Optional: FLASH_LINE_ARB_PREFETCH_EN adds a one-line next-line prefetch
// buffer fed through the PF_ISSUE / PF_WAIT states.
module flash_line_arbiter
  import flash_line_arb_pkg::*;
#(
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int NUM_REQ   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_line_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0]    fr_addr,
  output logic                 fr_rd,
  input  logic                 fr_done,
  input  logic [LINE_SIZE-1:0] fr_line
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_d;
  logic [PTR_W-1:0]     rr_ptr, owner, winner, dlv_idx;
  logic                 win_valid;
  logic [ADDR_W-1:0]    saddr, win_addr;
  logic [NUM_REQ-1:0]   gnt_q, done_q;
  logic [LINE_SIZE-1:0] line_q;
  logic                 accept, issue, deliver;
`ifdef FLASH_LINE_ARB_PREFETCH_EN
  logic [LINE_SIZE-1:0] pf_buf;
  logic [ADDR_W-1:0]    pf_addr;
  logic                 pf_valid, pf_arm, hit_q;
  logic                 pf_hit, pf_issue, pf_fill, dlv_buf;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign fr_addr  = line_addr(saddr);
  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.line = line_q;
  assign bus.busy = (state != IDLE);
  // A request merged at the end of a prefetch is delivered in the same edge
  // it is accepted, before owner has been updated.
  assign dlv_idx  = accept ? winner : owner;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    issue   = 1'b0;
    deliver = 1'b0;
`ifdef FLASH_LINE_ARB_PREFETCH_EN
    pf_hit   = 1'b0;
    pf_issue = 1'b0;
    pf_fill  = 1'b0;
    dlv_buf  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          accept = 1'b1;
`ifdef FLASH_LINE_ARB_PREFETCH_EN
          if (pf_valid && line_addr(win_addr) == pf_addr) begin
            pf_hit  = 1'b1;
            state_d = WAIT;
          end else begin
            issue   = 1'b1;
            state_d = ISSUE;
          end
`else
          issue   = 1'b1;
          state_d = ISSUE;
`endif
        end
`ifdef FLASH_LINE_ARB_PREFETCH_EN
        else if (pf_arm) begin
          pf_issue = 1'b1;
          state_d  = PF_ISSUE;
        end
`endif
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
`ifdef FLASH_LINE_ARB_PREFETCH_EN
        if (hit_q) begin
          deliver = 1'b1;
          dlv_buf = 1'b1;
          state_d = IDLE;
        end else
`endif
        if (fr_done) begin
          deliver = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef FLASH_LINE_ARB_PREFETCH_EN
      PF_ISSUE: state_d = PF_WAIT;
      PF_WAIT: begin
        // The prefetch always runs to completion; a matching request is
        // served straight from the returning line.
        if (fr_done) begin
          state_d = IDLE;
          if (win_valid && line_addr(win_addr) == line_addr(saddr)) begin
            accept  = 1'b1;
            deliver = 1'b1;
          end else begin
            pf_fill = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= PTR_W'(NUM_REQ - 1);
      owner  <= '0;
      saddr  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      line_q <= '0;
      fr_rd  <= 1'b0;
`ifdef FLASH_LINE_ARB_PREFETCH_EN
      pf_valid <= 1'b0;
      pf_arm   <= 1'b0;
      pf_addr  <= '0;
      hit_q    <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      state  <= state_d;
      gnt_q  <= '0;
      done_q <= '0;
      fr_rd  <= issue;
      if (accept) begin
        owner  <= winner;
        rr_ptr <= winner;
        saddr  <= win_addr;
        gnt_q  <= onehot(winner);
      end
      if (deliver) begin
        done_q <= onehot(dlv_idx);
`ifdef FLASH_LINE_ARB_PREFETCH_EN
        line_q <= dlv_buf ? pf_buf : fr_line;
`else
        line_q <= fr_line;
`endif
      end
`ifdef FLASH_LINE_ARB_PREFETCH_EN
      hit_q <= pf_hit;
      if (accept) begin
        pf_valid <= 1'b0;
        pf_arm   <= 1'b0;
      end
      if (deliver) pf_arm <= 1'b1;
      if (pf_issue) begin
        fr_rd  <= 1'b1;
        pf_arm <= 1'b0;
        saddr  <= saddr + ADDR_W'(LINE_BYTES);
      end
      if (pf_fill) begin
        pf_valid <= 1'b1;
        pf_addr  <= line_addr(saddr);
      end
`endif
    end
  end

`ifdef FLASH_LINE_ARB_PREFETCH_EN
  // NOTE: the prefetch buffer is data qualified by pf_valid, so it is left
  // out of reset.
  always_ff @(posedge clk) begin
    if (pf_fill) pf_buf <= fr_line;
  end
`endif

endmodule
